score_display: RTL and testbench
================================

Name: score_display

Overview:
- Downstream of the graphic stage; consumes its 11-bit score_out.
- Converts the binary score to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto the board's 4-digit, active-low, common-anode 7-segment display.
- Also exposes the BCD value and a busy flag for debug and verification.

Parameters:
- REFRESH_BITS, 17: width of the free-running refresh counter. The top 2 bits select the active digit (~763 Hz scan at 100 MHz).
- BLANK_LZ, 1: when 1, leading-zero digits are blanked. Digit 0 is never blanked.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- score  in  11  binary score from graphic, 0..2047
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- an  out  4  digit anodes, active-low; an[0] is the rightmost (ones) digit
- bcd  out  16  last completed conversion {thousands,hundreds,tens,ones}
- busy  out  1  high while a conversion is in progress

Behaviour:
- Reset (reset==0 at a clk edge):
  - seg=8'hFF, an=4'hF, bcd=16'h0000, busy=0.
  - state=IDLE, last_score=0, refresh counter=0.
  - Reset mid-conversion aborts the conversion; the partial result is discarded.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: if score != last_score, capture score into the shift register, clear scratch BCD, set shift count=0, set last_score=score, go to SHIFT, busy=1. Otherwise stay in IDLE.
  - SHIFT, one bit per cycle:
    - First, every scratch BCD nibble >=5 gets +3.
    - Then shift {bcd_scratch, bin} left by 1.
    - After the 11th shift, go to DONE.
  - DONE: copy scratch to bcd, set busy=0, return to IDLE.
  - Latency: score change sampled at edge N; bcd valid after edge N+12, so 13 edges including the capture edge.
- Score changes while busy are ignored until IDLE. The IDLE compare then picks up the newest value; intermediate values may be skipped.
- A score that returns to last_score while busy triggers no new conversion.
- Arithmetic:
  - Nibble adjust is 4-bit; the value is always <=12 after adding 3, so no overflow.
  - Max input 2047 gives thousands nibble <=2.
  - Scratch register is 16 bits; bits shifted out the top are always zero.
- Display multiplexing:
  - Refresh counter increments every clk and wraps from 2^REFRESH_BITS-1 to 0.
  - Digit index d = counter[REFRESH_BITS-1 -: 2].
  - seg and an are registered, so they follow d by one clk.
  - an = ~(4'b0001 << d).
  - seg = decode of bcd nibble d; dp is always off (bit7=1).
- Blanking (BLANK_LZ=1): digit k>0 is blanked when all nibbles k..3 are zero.
  - A blanked digit drives seg=8'hFF; the anode is still driven.
- Display uses the bcd register only. It never shows a partial conversion.

Decomposition:
- Shared package (ddr2_pkg):
  - SCORE_W=11.
  - Segment constants, active-low {dp,gfedcba}: SEG_0=8'hC0, SEG_1=8'hF9, SEG_2=8'hA4, SEG_3=8'hB0, SEG_4=8'h99, SEG_5=8'h92, SEG_6=8'h82, SEG_7=8'hF8, SEG_8=8'h80, SEG_9=8'h90, SEG_OFF=8'hFF.
  - Conversion state enum {IDLE, SHIFT, DONE}.
- Sub-module bin2bcd_seq: the conversion FSM.
  - Ports: clk, reset, bin[10:0], start, bcd[15:0], busy, done.
- The top level holds the change detector, refresh counter, digit mux and segment decode.

Test Plan:
- Hold reset=0 for 3 clks with score=500 -> seg=8'hFF, an=4'hF, bcd=0, busy=0. Release reset -> busy rises next edge; bcd=16'h0500 13 edges after release.
- score 0->1234 -> busy high for exactly 12 cycles; bcd=16'h1234. With REFRESH_BITS=4, an cycles E,D,B,7 with seg C0... order F9(d0=4→99)... Check: an=E shows 8'h99, an=D shows 8'hB0, an=B shows 8'hA4, an=7 shows 8'hF9.
- score=2047 (max) -> bcd=16'h2047, no nibble exceeds 9. score=9 with BLANK_LZ=1 -> digits 1..3 seg=8'hFF, digit0 seg=8'h90.
- score 100 then 101 three cycles later (mid-conversion) -> bcd=16'h0100 first. A second conversion starts in IDLE, giving final bcd=16'h0101.
- Start converting 1999, assert reset=0 at cycle 5 of SHIFT for 1 clk -> bcd=0, busy=0. After release, conversion reruns and bcd=16'h1999.
- score=0 with BLANK_LZ=1 -> only an[0] digit shows 8'hC0, other digits 8'hFF. With BLANK_LZ=0, all four show 8'hC0.

Source files
------------

// File: rtl/ddr2_pkg.sv
// Shared types and constants for the score display path: score width, active-low
// 7-segment patterns {dp,g,f,e,d,c,b,a} and the conversion FSM state type.
package ddr2_pkg;

   localparam int unsigned SCORE_W = 11;

   localparam logic [7:0] SEG_0   = 8'hC0;
   localparam logic [7:0] SEG_1   = 8'hF9;
   localparam logic [7:0] SEG_2   = 8'hA4;
   localparam logic [7:0] SEG_3   = 8'hB0;
   localparam logic [7:0] SEG_4   = 8'h99;
   localparam logic [7:0] SEG_5   = 8'h92;
   localparam logic [7:0] SEG_6   = 8'h82;
   localparam logic [7:0] SEG_7   = 8'hF8;
   localparam logic [7:0] SEG_8   = 8'h80;
   localparam logic [7:0] SEG_9   = 8'h90;
   localparam logic [7:0] SEG_OFF = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_e;

   // Non-decimal nibbles cannot occur; they decode to a dark digit.
   function automatic logic [7:0] seg_decode(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, 11 shifts per conversion.
// bcd holds the scratch result and is complete while done is high.
module bin2bcd_seq
   import ddr2_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [SCORE_W-1:0] bin,
   input  logic               start,
   output logic [15:0]        bcd,
   output logic               busy,
   output logic               done
);

   conv_state_e        state_q, state_d;
   logic [SCORE_W-1:0] bin_q, bin_d;
   logic [15:0]        scratch_q, scratch_d;
   logic [3:0]         count_q, count_d;
   logic [15:0]        adj;

   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < 4; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scratch_d = scratch_q;
      count_d   = count_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d     = bin;
               scratch_d = 16'h0000;
               count_d   = 4'd0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // The top scratch bit is always zero here, so dropping it loses nothing.
            {scratch_d, bin_d} = {adj[14:0], bin_q, 1'b0};
            count_d            = count_q + 4'd1;
            if (count_q == 4'd10) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         scratch_q <= 16'h0000;
         count_q   <= 4'd0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scratch_q <= scratch_d;
         count_q   <= count_d;
      end
   end

   assign bcd  = scratch_q;
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: rtl/score_display.sv
// Binary score to 4-digit multiplexed active-low 7-segment display, with change
// detection, registered BCD result and optional leading-zero blanking.
module score_display
   import ddr2_pkg::*;
#(
   parameter int unsigned REFRESH_BITS = 17,
   parameter int unsigned BLANK_LZ     = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SCORE_W-1:0] score,
   output logic [7:0]         seg,
   output logic [3:0]         an,
   output logic [15:0]        bcd,
   output logic               busy
);

   logic [SCORE_W-1:0]      last_score_q;
   logic [15:0]             bcd_q;
   logic [REFRESH_BITS-1:0] refresh_q;
   logic [7:0]              seg_q, seg_d;
   logic [3:0]              an_q, an_d;
   logic                    start;
   logic                    conv_busy;
   logic                    conv_done;
   logic [15:0]             conv_bcd;
   logic [1:0]              digit;
   logic [3:0]              blank;

   // A change seen while converting waits for IDLE; only the newest value is taken.
   assign start = (score != last_score_q) && !conv_busy;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .bin   (score),
      .start (start),
      .bcd   (conv_bcd),
      .busy  (conv_busy),
      .done  (conv_done)
   );

   assign digit = refresh_q[REFRESH_BITS-1 -: 2];

   assign blank[0] = 1'b0;
   assign blank[3] = (bcd_q[15:12] == 4'd0);
   assign blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
   assign blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);

   always_comb begin
      an_d  = ~(4'b0001 << digit);
      seg_d = seg_decode(bcd_q[{digit, 2'b00} +: 4]);
      if ((BLANK_LZ != 0) && blank[digit]) begin
         seg_d = SEG_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_score_q <= '0;
         bcd_q        <= 16'h0000;
         refresh_q    <= '0;
         seg_q        <= SEG_OFF;
         an_q         <= 4'hF;
      end else begin
         if (start) begin
            last_score_q <= score;
         end
         if (conv_done) begin
            bcd_q <= conv_bcd;
         end
         refresh_q <= refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign bcd  = bcd_q;
   assign busy = conv_busy;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench: stimulus queues expected BCD results, a monitor pops them on
// each busy fall; display scan is checked against a bench-side segment model.
module tb_score_display;

   localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [10:0] score = 11'd0;
   logic [7:0]  seg0, seg1;
   logic [3:0]  an0, an1;
   logic [15:0] bcd0, bcd1;
   logic        busy0, busy1;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];
   logic prev_busy = 1'b0;
   int   busy_len = 0;

   score_display #(.REFRESH_BITS(4), .BLANK_LZ(1)) dut_lz (
      .clk(clk), .reset(reset), .score(score),
      .seg(seg0), .an(an0), .bcd(bcd0), .busy(busy0)
   );

   score_display #(.REFRESH_BITS(4), .BLANK_LZ(0)) dut_nolz (
      .clk(clk), .reset(reset), .score(score),
      .seg(seg1), .an(an1), .bcd(bcd1), .busy(busy1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every completed conversion must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset) begin
         prev_busy = 1'b0;
         busy_len  = 0;
      end else begin
         if (busy0) busy_len++;
         if (prev_busy && !busy0) begin
            chk("busy_len", busy_len, 12);
            chk("busy_match", {31'd0, busy1}, 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_conv: got %0h expected none", bcd0);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               chk("bcd_lz", {16'd0, bcd0}, {16'd0, e});
               chk("bcd_nolz", {16'd0, bcd1}, {16'd0, e});
            end
            busy_len = 0;
         end
         prev_busy = busy0;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL wait_idle: got timeout expected conversion done, %0d pending",
                  exp_q.size());
      end
   endtask

   function automatic int an_index(input logic [3:0] a);
      case (a)
         4'hE:    return 0;
         4'hD:    return 1;
         4'hB:    return 2;
         4'h7:    return 3;
         default: return -1;
      endcase
   endfunction

   task automatic check_display(input logic [15:0] v);
      logic [3:0] seen = 4'h0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 16; s++) begin
         int k0, k1;
         logic [7:0] e0, e1;
         @(negedge clk);
         k0 = an_index(an0);
         k1 = an_index(an1);
         if (k0 < 0 || k1 < 0) begin
            checks++;
            errors++;
            $display("FAIL an_pattern: got %0h/%0h expected one low anode", an0, an1);
         end else begin
            seen[k0] = 1'b1;
            e1 = SEG_TAB[v[4*k1 +: 4]];
            e0 = ((k0 > 0) && ((v >> (4 * k0)) == 16'd0)) ? 8'hFF : SEG_TAB[v[4*k0 +: 4]];
            chk($sformatf("seg_lz_%0h_d%0d", v, k0), {24'd0, seg0}, {24'd0, e0});
            chk($sformatf("seg_nolz_%0h_d%0d", v, k1), {24'd0, seg1}, {24'd0, e1});
         end
      end
      chk("digits_seen", {28'd0, seen}, 32'hF);
   endtask

   localparam int NV = 4;
   logic [10:0] vec_in  [NV] = '{11'd0, 11'd1234, 11'd2047, 11'd9};
   logic [15:0] vec_exp [NV] = '{16'h0000, 16'h1234, 16'h2047, 16'h0009};

   initial begin
      reset = 1'b0;
      score = 11'd500;
      repeat (3) @(negedge clk);
      chk("rst_seg", {24'd0, seg0}, 32'hFF);
      chk("rst_an", {28'd0, an0}, 32'hF);
      chk("rst_bcd", {16'd0, bcd0}, 32'h0);
      chk("rst_busy", {31'd0, busy0}, 32'h0);
      chk("rst_seg_nolz", {24'd0, seg1}, 32'hFF);

      exp_q.push_back(16'h0500);
      reset = 1'b1;
      @(negedge clk);
      chk("busy_rise", {31'd0, busy0}, 32'h1);
      wait_idle();
      check_display(16'h0500);

      for (int i = 0; i < NV; i++) begin
         score = vec_in[i];
         exp_q.push_back(vec_exp[i]);
         wait_idle();
         check_display(vec_exp[i]);
      end

      // Change arrives mid-conversion: first result is the old value, then a rerun.
      score = 11'd100;
      exp_q.push_back(16'h0100);
      repeat (3) @(negedge clk);
      score = 11'd101;
      exp_q.push_back(16'h0101);
      wait_idle();
      check_display(16'h0101);

      // Reset during SHIFT discards the partial result; the score reconverts after.
      score = 11'd1999;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_bcd", {16'd0, bcd0}, 32'h0);
      chk("abort_busy", {31'd0, busy0}, 32'h0);
      chk("abort_seg", {24'd0, seg0}, 32'hFF);
      chk("abort_an", {28'd0, an0}, 32'hF);
      reset = 1'b1;
      exp_q.push_back(16'h1999);
      wait_idle();
      check_display(16'h1999);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
